alu_stim_sequencer: RTL



---
 rtl/alu_test_pkg.sv | 28 ++
 rtl/lfsr32_step.sv | 11 +
 rtl/alu_stim_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_test_pkg.sv
// rtl/alu_test_pkg.sv - shared types, constants and instruction encoder for the ALU32 stimulus path
package alu_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    // R-type word: opcode field zero, funct field carries the op index.
    function automatic logic [31:0] encode_rtype(input logic [5:0] op);
        logic [31:0] word;
        word                     = '0;
        word[OPC_MSB:OPC_LSB]    = 6'b000000;
        word[FUNCT_MSB:FUNCT_LSB] = op;
        return word;
    endfunction

endpackage

// File: rtl/lfsr32_step.sv
// rtl/lfsr32_step.sv - one combinational step of the 32-bit Galois operand LFSR
module lfsr32_step
    import alu_test_pkg::*;
(
    input  logic [31:0] cur,
    output logic [31:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0000_0000);

endmodule

// File: rtl/alu_stim_sequencer.sv
// rtl/alu_stim_sequencer.sv - self-running ALU32 operand/instruction sweep with result signature
module alu_stim_sequencer
    import alu_test_pkg::*;
#(
    parameter int          NUM_OPS       = 16,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED     = 32'hACE12345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] alu_out,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [31:0] instr,
    output logic        busy,
    output logic        done,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [5:0]  op_idx,
    output logic [31:0] signature
);

    localparam logic [5:0]  LAST_OP     = 6'(NUM_OPS - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_n1;
    logic [31:0] lfsr_n2;
    logic [15:0] settle_cnt;

    // Two chained steps give both operands of one op and the seed for the next.
    lfsr32_step u_step1 (
        .cur (lfsr),
        .nxt (lfsr_n1)
    );

    lfsr32_step u_step2 (
        .cur (lfsr_n1),
        .nxt (lfsr_n2)
    );

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr       <= LFSR_SEED;
            settle_cnt <= '0;
            in1        <= '0;
            in2        <= '0;
            instr      <= '0;
            res_data   <= '0;
            op_idx     <= '0;
            signature  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        op_idx    <= '0;
                        signature <= '0;
                        lfsr      <= LFSR_SEED;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    in1        <= lfsr;
                    in2        <= lfsr_n1;
                    instr      <= encode_rtype(op_idx);
                    lfsr       <= lfsr_n2;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 16'd1;
                    // res_valid is raised on entry so it is high exactly during CAPTURE.
                    if (settle_cnt <= 16'd1) begin
                        state     <= ST_CAPTURE;
                        res_valid <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    res_data  <= alu_out;
                    signature <= {signature[30:0], signature[31]} ^ alu_out;
                    if (op_idx == LAST_OP) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        op_idx <= op_idx + 6'd1;
                        state  <= ST_DRIVE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
